// File: rtl/utils_pkg.sv
// Shared types for the pipeline hazard/redirect/write-back control slice.
// Payload structs use the widest supported widths; users cast to their own widths.
package utils_pkg;

  localparam int unsigned RA_W_MAX = 8;
  localparam int unsigned XLEN_MAX = 64;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic                valid;
    logic [RA_W_MAX-1:0] rd;
    logic [XLEN_MAX-1:0] data;
  } s_wb_hold_t;

  typedef struct packed {
    logic [RA_W_MAX-1:0] rs1_addr;
    logic                rs1_sel;
    logic [RA_W_MAX-1:0] rs2_addr;
    logic                rs2_sel;
  } s_id_regs_t;

  // A source register matters only when selected and not x0.
  function automatic logic rs_used(input logic sel, input logic [RA_W_MAX-1:0] addr);
    return sel && (addr != '0);
  endfunction

endpackage

// File: rtl/ld_scoreboard.sv
// Per-register pending-load bits plus the count of loads in flight.
// Responses arriving with nothing in flight are dropped.
module ld_scoreboard #(
  parameter int unsigned RA_W      = 5,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ld_acc,
  input  logic [RA_W-1:0]                    ld_rd,
  input  logic                               rsp_vld,
  input  logic [RA_W-1:0]                    rsp_rd,
  output logic [(2**RA_W)-1:0]               sb,
  output logic [$clog2(MAX_OUTST+1)-1:0]     cnt,
  output logic                               rsp_ok_c
);

  localparam int unsigned NREG  = 2 ** RA_W;
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

  logic [NREG-1:0]  sb_nx;
  logic [CNT_W-1:0] cnt_nx;

  assign rsp_ok_c = rsp_vld && (cnt != '0);

  // Clear first so a same-cycle set on the same register wins.
  always_comb begin
    sb_nx = sb;
    if (rsp_ok_c) begin
      sb_nx[rsp_rd] = 1'b0;
    end
    if (ld_acc && (ld_rd != '0)) begin
      sb_nx[ld_rd] = 1'b1;
    end
    sb_nx[0] = 1'b0;
  end

  always_comb begin
    cnt_nx = cnt;
    if (ld_acc && !rsp_ok_c) begin
      cnt_nx = cnt + CNT_W'(1);
    end else if (!ld_acc && rsp_ok_c) begin
      cnt_nx = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb  <= '0;
      cnt <= '0;
    end else begin
      sb  <= sb_nx;
      cnt <= cnt_nx;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(ld_acc && !rsp_ok_c && (cnt == CNT_W'(MAX_OUTST))));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline control: load-use/RAW stall, branch/jump redirect with flush,
// and single-port register-file write arbitration (LSU > held ALU > ALU).
module hazard_ctrl
  import utils_pkg::*;
#(
  parameter int unsigned RA_W      = 5,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned FLUSH_CYC = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [RA_W-1:0]                id_rs1_addr_i,
  input  logic                           id_rs1_sel_i,
  input  logic [RA_W-1:0]                id_rs2_addr_i,
  input  logic                           id_rs2_sel_i,
  input  logic                           ex_valid_i,
  input  logic [RA_W-1:0]                ex_rd_addr_i,
  input  logic                           ex_is_load_i,
  input  logic                           ex_we_rd_i,
  input  logic [XLEN-1:0]                ex_result_i,
  input  logic                           br_take_i,
  input  logic [XLEN-1:0]                br_addr_i,
  input  logic                           jmp_act_i,
  input  logic [XLEN-1:0]                jmp_addr_i,
  input  logic                           lsu_ld_acc_i,
  input  logic                           lsu_rsp_vld_i,
  input  logic [RA_W-1:0]                lsu_rsp_rd_i,
  input  logic [XLEN-1:0]                lsu_rsp_data_i,
  output logic                           stall_o,
  output logic                           flush_o,
  output logic                           fetch_req_o,
  output logic [XLEN-1:0]                fetch_addr_o,
  output logic                           wb_we_o,
  output logic [RA_W-1:0]                wb_rd_addr_o,
  output logic [XLEN-1:0]                wb_rd_data_o,
  output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt_o
);

  localparam int unsigned NREG  = 2 ** RA_W;
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
  localparam int unsigned FC_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  hz_state_t        state;
  logic [FC_W-1:0]  fcnt;
  s_wb_hold_t       hold;
  s_wb_hold_t       hold_nx;
  s_id_regs_t       id;
  logic [NREG-1:0]  sb;
  logic             rsp_ok_c;
  logic             ex_load_c;
  logic             ld_acc_c;
  logic             haz_a_c;
  logic             haz_b_c;
  logic             full_c;
  logic             redirect_c;
  logic             alu_wr_c;
  logic             lsu_wr_c;
  logic             rs1_use_c;
  logic             rs2_use_c;
  logic [RA_W_MAX-1:0] ex_rd_c;

  assign ex_load_c = ex_valid_i && ex_is_load_i;
  assign ld_acc_c  = ex_load_c && lsu_ld_acc_i;

  ld_scoreboard #(
    .RA_W      (RA_W),
    .MAX_OUTST (MAX_OUTST)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .ld_acc   (ld_acc_c),
    .ld_rd    (ex_rd_addr_i),
    .rsp_vld  (lsu_rsp_vld_i),
    .rsp_rd   (lsu_rsp_rd_i),
    .sb       (sb),
    .cnt      (outst_cnt_o),
    .rsp_ok_c (rsp_ok_c)
  );

  // Hazard detection against the scoreboard and the load currently in EX.
  always_comb begin
    id.rs1_addr = RA_W_MAX'(id_rs1_addr_i);
    id.rs1_sel  = id_rs1_sel_i;
    id.rs2_addr = RA_W_MAX'(id_rs2_addr_i);
    id.rs2_sel  = id_rs2_sel_i;
    ex_rd_c     = RA_W_MAX'(ex_rd_addr_i);
    rs1_use_c   = rs_used(id.rs1_sel, id.rs1_addr);
    rs2_use_c   = rs_used(id.rs2_sel, id.rs2_addr);
    haz_a_c     = (rs1_use_c && sb[RA_W'(id.rs1_addr)]) ||
                  (rs2_use_c && sb[RA_W'(id.rs2_addr)]);
    haz_b_c     = ex_load_c &&
                  ((rs1_use_c && (id.rs1_addr == ex_rd_c)) ||
                   (rs2_use_c && (id.rs2_addr == ex_rd_c)));
    full_c      = ex_load_c && (outst_cnt_o == CNT_W'(MAX_OUTST));
  end

  assign stall_o = rst && (haz_a_c || haz_b_c || full_c || hold.valid) && (state == IDLE);

  // Redirect is a same-cycle pulse; branch wins over jump.
  assign redirect_c   = br_take_i || jmp_act_i;
  assign fetch_req_o  = rst && redirect_c;
  assign fetch_addr_o = !fetch_req_o ? '0 : (br_take_i ? br_addr_i : jmp_addr_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      fcnt    <= '0;
      flush_o <= 1'b0;
    end else if (redirect_c) begin
      state   <= FLUSH;
      fcnt    <= FC_W'(FLUSH_CYC - 1);
      flush_o <= 1'b1;
    end else if (state == FLUSH) begin
      if (fcnt == '0) begin
        state   <= IDLE;
        flush_o <= 1'b0;
      end else begin
        fcnt <= fcnt - FC_W'(1);
      end
    end
  end

  // A stalled EX instruction repeats, so its ALU write is issued once it is released.
  assign alu_wr_c = rst && ex_valid_i && ex_we_rd_i && !ex_is_load_i &&
                    (ex_rd_addr_i != '0) && !stall_o;
  assign lsu_wr_c = rsp_ok_c && (lsu_rsp_rd_i != '0);

  // Write-port select; a losing ALU write parks in the hold buffer if it drains this cycle.
  always_comb begin
    wb_we_o      = 1'b0;
    wb_rd_addr_o = '0;
    wb_rd_data_o = '0;
    hold_nx      = hold;
    if (lsu_wr_c) begin
      wb_we_o      = 1'b1;
      wb_rd_addr_o = lsu_rsp_rd_i;
      wb_rd_data_o = lsu_rsp_data_i;
      if (!hold.valid && alu_wr_c) begin
        hold_nx.valid = 1'b1;
        hold_nx.rd    = RA_W_MAX'(ex_rd_addr_i);
        hold_nx.data  = XLEN_MAX'(ex_result_i);
      end
    end else if (hold.valid) begin
      wb_we_o       = 1'b1;
      wb_rd_addr_o  = RA_W'(hold.rd);
      wb_rd_data_o  = XLEN'(hold.data);
      hold_nx.valid = 1'b0;
      if (alu_wr_c) begin
        hold_nx.valid = 1'b1;
        hold_nx.rd    = RA_W_MAX'(ex_rd_addr_i);
        hold_nx.data  = XLEN_MAX'(ex_result_i);
      end
    end else if (alu_wr_c) begin
      wb_we_o      = 1'b1;
      wb_rd_addr_o = ex_rd_addr_i;
      wb_rd_data_o = ex_result_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold <= '0;
    end else begin
      hold <= hold_nx;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed cycle-by-cycle vectors for hazard_ctrl (MAX_OUTST=2, FLUSH_CYC=2),
// plus a hand-written asynchronous reset sequence with loads in flight.
module tb_hazard_ctrl;

  localparam int unsigned RA_W      = 5;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned MAX_OUTST = 2;
  localparam int unsigned FLUSH_CYC = 2;
  localparam int unsigned CNT_W     = $clog2(MAX_OUTST + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [RA_W-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr, lsu_rsp_rd;
  logic id_rs1_sel, id_rs2_sel, ex_valid, ex_is_load, ex_we_rd;
  logic [XLEN-1:0] ex_result, br_addr, jmp_addr, lsu_rsp_data;
  logic br_take, jmp_act, lsu_ld_acc, lsu_rsp_vld;
  logic stall, flush, fetch_req, wb_we;
  logic [XLEN-1:0] fetch_addr, wb_rd_data;
  logic [RA_W-1:0] wb_rd_addr;
  logic [CNT_W-1:0] outst_cnt;

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .RA_W(RA_W), .XLEN(XLEN), .MAX_OUTST(MAX_OUTST), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr_i(id_rs1_addr), .id_rs1_sel_i(id_rs1_sel),
    .id_rs2_addr_i(id_rs2_addr), .id_rs2_sel_i(id_rs2_sel),
    .ex_valid_i(ex_valid), .ex_rd_addr_i(ex_rd_addr), .ex_is_load_i(ex_is_load),
    .ex_we_rd_i(ex_we_rd), .ex_result_i(ex_result),
    .br_take_i(br_take), .br_addr_i(br_addr), .jmp_act_i(jmp_act), .jmp_addr_i(jmp_addr),
    .lsu_ld_acc_i(lsu_ld_acc), .lsu_rsp_vld_i(lsu_rsp_vld),
    .lsu_rsp_rd_i(lsu_rsp_rd), .lsu_rsp_data_i(lsu_rsp_data),
    .stall_o(stall), .flush_o(flush), .fetch_req_o(fetch_req), .fetch_addr_o(fetch_addr),
    .wb_we_o(wb_we), .wb_rd_addr_o(wb_rd_addr), .wb_rd_data_o(wb_rd_data),
    .outst_cnt_o(outst_cnt)
  );

  typedef struct packed {
    logic [4:0]  rs1;   logic rs1_sel;
    logic [4:0]  rs2;   logic rs2_sel;
    logic        ex_v;  logic [4:0] ex_rd; logic ex_ld; logic ex_we; logic [31:0] ex_res;
    logic        br;    logic [31:0] br_a;
    logic        jmp;   logic [31:0] jmp_a;
    logic        ld_acc;
    logic        rsp_v; logic [4:0] rsp_rd; logic [31:0] rsp_d;
    logic        e_stall; logic e_flush; logic e_freq; logic [31:0] e_faddr;
    logic        e_we;  logic [4:0] e_rd; logic [31:0] e_data; logic [1:0] e_cnt;
  } vec_t;

  vec_t vq[$];
  vec_t v;

  task nv();                                   v = '0; endtask
  task push();                                 vq.push_back(v); endtask
  task ex_load(input logic [4:0] rd, input logic acc);
    v.ex_v = 1'b1; v.ex_ld = 1'b1; v.ex_rd = rd; v.ld_acc = acc;
  endtask
  task ex_alu(input logic [4:0] rd, input logic [31:0] res);
    v.ex_v = 1'b1; v.ex_we = 1'b1; v.ex_rd = rd; v.ex_res = res;
  endtask
  task rsp(input logic [4:0] rd, input logic [31:0] d);
    v.rsp_v = 1'b1; v.rsp_rd = rd; v.rsp_d = d;
  endtask
  task rs1(input logic [4:0] a);               v.rs1 = a; v.rs1_sel = 1'b1; endtask
  task rs2(input logic [4:0] a);               v.rs2 = a; v.rs2_sel = 1'b1; endtask
  task ex(input logic s, input logic f, input logic [1:0] c);
    v.e_stall = s; v.e_flush = f; v.e_cnt = c;
  endtask
  task wb(input logic [4:0] rd, input logic [31:0] d);
    v.e_we = 1'b1; v.e_rd = rd; v.e_data = d;
  endtask
  task fr(input logic [31:0] a);               v.e_freq = 1'b1; v.e_faddr = a; endtask

  task drive(input vec_t x);
    id_rs1_addr = x.rs1;  id_rs1_sel = x.rs1_sel;
    id_rs2_addr = x.rs2;  id_rs2_sel = x.rs2_sel;
    ex_valid = x.ex_v; ex_rd_addr = x.ex_rd; ex_is_load = x.ex_ld;
    ex_we_rd = x.ex_we; ex_result = x.ex_res;
    br_take = x.br; br_addr = x.br_a; jmp_act = x.jmp; jmp_addr = x.jmp_a;
    lsu_ld_acc = x.ld_acc; lsu_rsp_vld = x.rsp_v; lsu_rsp_rd = x.rsp_rd; lsu_rsp_data = x.rsp_d;
  endtask

  task chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h, expected %0h", tag, nm, act, exp);
    end
  endtask

  task check_vec(input string tag, input vec_t x);
    chk(tag, "stall",      32'(stall),      32'(x.e_stall));
    chk(tag, "flush",      32'(flush),      32'(x.e_flush));
    chk(tag, "fetch_req",  32'(fetch_req),  32'(x.e_freq));
    chk(tag, "fetch_addr", fetch_addr,      x.e_faddr);
    chk(tag, "wb_we",      32'(wb_we),      32'(x.e_we));
    chk(tag, "wb_rd",      32'(wb_rd_addr), 32'(x.e_rd));
    chk(tag, "wb_data",    wb_rd_data,      x.e_data);
    chk(tag, "outst_cnt",  32'(outst_cnt),  32'(x.e_cnt));
  endtask

  initial begin
    // Load-use on x5: stall from EX match, then from scoreboard, until the response.
    nv(); ex_load(5, 1); rs1(5); ex(1, 0, 0); push();                       // v0
    nv(); rs1(5); ex(1, 0, 1); push();                                      // v1
    nv(); rs1(5); ex(1, 0, 1); push();                                      // v2
    nv(); rs1(5); rsp(5, 32'h55); ex(1, 0, 1); wb(5, 32'h55); push();       // v3
    nv(); rs1(5); ex(0, 0, 0); push();                                      // v4
    // x0 dependencies never stall; the x0 load is counted but never written.
    nv(); ex_load(0, 1); rs1(0); rs2(0); ex(0, 0, 0); push();               // v5
    nv(); rs1(0); ex(0, 0, 1); push();                                      // v6
    nv(); rsp(0, 32'hDEAD); ex(0, 0, 1); push();                            // v7
    nv(); ex(0, 0, 0); push();                                              // v8
    // Outstanding limit of 2.
    nv(); ex_load(6, 1); ex(0, 0, 0); push();                               // v9
    nv(); ex_load(7, 1); ex(0, 0, 1); push();                               // v10
    nv(); ex_load(8, 0); ex(1, 0, 2); push();                               // v11
    nv(); ex_load(8, 0); rsp(6, 32'h66); ex(1, 0, 2); wb(6, 32'h66); push(); // v12
    nv(); ex_load(8, 0); ex(0, 0, 1); push();                               // v13
    nv(); rs2(7); rsp(7, 32'h77); ex(1, 0, 1); wb(7, 32'h77); push();       // v14
    nv(); rs2(7); ex(0, 0, 0); push();                                      // v15
    // Redirect with overlapping jump during flush.
    nv(); v.br = 1'b1; v.br_a = 32'h100; fr(32'h100); ex(0, 0, 0); push();  // v16
    nv(); ex(0, 1, 0); push();                                              // v17
    nv(); v.jmp = 1'b1; v.jmp_a = 32'h200; fr(32'h200); ex(0, 1, 0); push(); // v18
    nv(); ex(0, 1, 0); push();                                              // v19
    nv(); ex(0, 1, 0); push();                                              // v20
    nv(); ex(0, 0, 0); push();                                              // v21
    // Branch beats jump; flush masks a load-use stall.
    nv(); v.br = 1'b1; v.br_a = 32'h300; v.jmp = 1'b1; v.jmp_a = 32'h400;
          fr(32'h300); ex(0, 0, 0); push();                                 // v22
    nv(); ex(0, 1, 0); push();                                              // v23
    nv(); ex_load(9, 0); rs1(9); ex(0, 1, 0); push();                       // v24
    nv(); ex_load(9, 0); rs1(9); ex(1, 0, 0); push();                       // v25
    // ALU/LSU collision: LSU first, held ALU write next with one stall cycle.
    nv(); ex_load(4, 1); ex(0, 0, 0); push();                               // v26
    nv(); ex_alu(3, 32'hA); rsp(4, 32'hB); ex(0, 0, 1); wb(4, 32'hB); push(); // v27
    nv(); ex_alu(2, 32'hC); ex(1, 0, 0); wb(3, 32'hA); push();              // v28
    nv(); ex_alu(2, 32'hC); ex(0, 0, 0); wb(2, 32'hC); push();              // v29
    nv(); ex_alu(0, 32'hF); ex(0, 0, 0); push();                            // v30
    // Held write waits out a second LSU response.
    nv(); ex_load(10, 1); ex(0, 0, 0); push();                              // v31
    nv(); ex_load(11, 1); ex(0, 0, 1); push();                              // v32
    nv(); ex_alu(12, 32'h12); rsp(10, 32'h1010); ex(0, 0, 2); wb(10, 32'h1010); push(); // v33
    nv(); ex_alu(13, 32'h13); rsp(11, 32'h1111); ex(1, 0, 1); wb(11, 32'h1111); push(); // v34
    nv(); ex(1, 0, 0); wb(12, 32'h12); push();                              // v35
    nv(); ex(0, 0, 0); push();                                              // v36

    // Reset with live redirect and ALU write on the inputs: outputs must stay 0.
    rst = 1'b0;
    nv(); v.br = 1'b1; v.br_a = 32'h44; ex_alu(3, 32'h7); drive(v);
    #7;
    nv(); check_vec("reset", v);
    @(negedge clk);
    nv(); drive(v);
    rst = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      drive(vq[i]);
      @(negedge clk);
      check_vec($sformatf("v%0d", i), vq[i]);
    end

    // Asynchronous reset with two loads in flight, then a late response.
    @(posedge clk); #1; nv(); ex_load(5, 1); drive(v);
    @(posedge clk); #1; nv(); ex_load(6, 1); drive(v);
    @(posedge clk); #1; nv(); rs1(5); drive(v);
    @(negedge clk);
    nv(); ex(1, 0, 2); check_vec("pre_rst", v);
    #2;
    nv(); rs1(5); v.br = 1'b1; v.br_a = 32'h500; rsp(5, 32'h99); drive(v);
    rst = 1'b0;
    #1;
    nv(); check_vec("in_rst", v);
    nv(); rs1(5); drive(v);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1; nv(); rs1(5); rsp(5, 32'h99); drive(v);
    @(negedge clk);
    nv(); check_vec("late_rsp", v);
    @(posedge clk); #1; nv(); drive(v);
    @(negedge clk);
    nv(); check_vec("after_late", v);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
